arm_shift_pipe: RTL and testbench

- Parametrised, two-stage pipelined operand shifter for the ARM datapath, sitting between register-file read and the ALU B-operand.
- Covers all four operand-2 forms: immediate-amount shift, register-amount shift, rotated 8-bit immediate and branch offset.
- Produces full ARM carry-out semantics, including RRX and the #0/#32 encodings.
- Uses a valid/ready handshake so a stalled ALU back-pressures decode.

---
 rtl/arm_shift_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_arm_shift_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_shift_pipe.sv
// arm_shift_pipe: two-stage pipelined ARM operand-2 shifter with valid/ready flow control.
//   Stage 1 registers the operand and resolves the encoding into a canonical
//   operation and amount. Stage 2 performs the shift and registers the result.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        input handshake
//   mode, shift_type           operand-2 form and shift kind
//   shamt_imm, rs_amt          immediate / register shift amounts
//   rm_data                    value to shift
//   imm8, rot4                 rotated-immediate fields
//   branch_offset              signed 24-bit word offset
//   carry_in                   current C flag
//   in_tag / out_tag           sideband tag travelling with the operand
//   out_valid / out_ready      output handshake
//   shifted_data, carry_out    shifter result and carry
module arm_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  localparam int SW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [1:0]        shift_type,
  input  logic [SW-1:0]     shamt_imm,
  input  logic [7:0]        rs_amt,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [7:0]        imm8,
  input  logic [3:0]        rot4,
  input  logic [23:0]       branch_offset,
  input  logic              carry_in,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shifted_data,
  output logic              carry_out,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int AW = SW + 1;

  // Canonical operations resolved in stage 1.
  localparam logic [2:0] OP_PASS = 3'd0;  // result = value, C = carry_in
  localparam logic [2:0] OP_LSL  = 3'd1;
  localparam logic [2:0] OP_LSR  = 3'd2;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;  // amount 0..DATA_W-1, C = result msb
  localparam logic [2:0] OP_RRX  = 3'd5;
  localparam logic [2:0] OP_ZERO = 3'd6;  // logical shift past the width

  localparam logic [AW-1:0] AMT_FULL = AW'(DATA_W);
  localparam logic [7:0]    RS_FULL  = 8'(DATA_W);

  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_op_q, s1_op_d;
  logic [AW-1:0]     s1_amt_q, s1_amt_d;
  logic [DATA_W-1:0] s1_val_q, s1_val_d;
  logic              s1_cin_q, s1_cin_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_carry_q, s2_carry_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic s1_load, s2_load;

  assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  // Stage 1: decode encoding into op/amount.
  always_comb begin
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s1_op_d    = s1_op_q;
    s1_amt_d   = s1_amt_q;
    s1_val_d   = s1_val_q;
    s1_cin_d   = s1_cin_q;
    s1_tag_d   = s1_tag_q;
    if (s1_load) begin
      s1_val_d = rm_data;
      s1_cin_d = carry_in;
      s1_tag_d = in_tag;
      s1_op_d  = OP_PASS;
      s1_amt_d = '0;
      case (mode)
        2'b00: begin
          s1_amt_d = {1'b0, shamt_imm};
          if (shamt_imm == '0) begin
            // #0 encodings: LSR/ASR mean a full-width shift, ROR means RRX
            case (shift_type)
              2'b01:   begin s1_op_d = OP_LSR; s1_amt_d = AMT_FULL; end
              2'b10:   begin s1_op_d = OP_ASR; s1_amt_d = AMT_FULL; end
              2'b11:   s1_op_d = OP_RRX;
              default: s1_op_d = OP_PASS;
            endcase
          end else begin
            case (shift_type)
              2'b00:   s1_op_d = OP_LSL;
              2'b01:   s1_op_d = OP_LSR;
              2'b10:   s1_op_d = OP_ASR;
              default: s1_op_d = OP_ROR;
            endcase
          end
        end
        2'b01: begin
          if (rs_amt != 8'd0) begin
            case (shift_type)
              2'b00, 2'b01: begin
                if (rs_amt > RS_FULL) begin
                  s1_op_d = OP_ZERO;
                end else begin
                  s1_op_d  = (shift_type == 2'b00) ? OP_LSL : OP_LSR;
                  s1_amt_d = AW'(rs_amt);
                end
              end
              2'b10: begin
                s1_op_d  = OP_ASR;
                s1_amt_d = (rs_amt >= RS_FULL) ? AMT_FULL : AW'(rs_amt);
              end
              default: begin
                s1_op_d  = OP_ROR;
                s1_amt_d = {1'b0, rs_amt[SW-1:0]};
              end
            endcase
          end
        end
        2'b10: begin
          s1_val_d = DATA_W'(imm8);
          if (rot4 != 4'd0) begin
            s1_op_d  = OP_ROR;
            s1_amt_d = AW'({3'b000, rot4, 1'b0} & (RS_FULL - 8'd1));
          end
        end
        default: begin
          s1_val_d = DATA_W'({{DATA_W{branch_offset[23]}}, branch_offset, 2'b00});
        end
      endcase
    end
  end

  // Stage 2: shifts use one extra bit to catch the carry (last bit shifted out).
  logic [DATA_W:0]        wide_l, wide_r;
  logic signed [DATA_W:0] wide_a;
  logic [AW-1:0]          ror_inv;
  logic [DATA_W-1:0]      res;
  logic                   res_c;

  always_comb begin
    wide_l  = {1'b0, s1_val_q} << s1_amt_q;
    wide_r  = {s1_val_q, 1'b0} >> s1_amt_q;
    wide_a  = $signed({s1_val_q, 1'b0}) >>> s1_amt_q;
    ror_inv = AMT_FULL - s1_amt_q;
    res     = s1_val_q;
    res_c   = s1_cin_q;
    case (s1_op_q)
      OP_LSL: begin res = wide_l[DATA_W-1:0]; res_c = wide_l[DATA_W]; end
      OP_LSR: begin res = wide_r[DATA_W:1];   res_c = wide_r[0];      end
      OP_ASR: begin res = wide_a[DATA_W:1];   res_c = wide_a[0];      end
      OP_ROR: begin
        // amount 0 yields the unrotated value; left shift by DATA_W gives 0
        res   = (s1_val_q >> s1_amt_q) | (s1_val_q << ror_inv);
        res_c = res[DATA_W-1];
      end
      OP_RRX:  begin res = {s1_cin_q, s1_val_q[DATA_W-1:1]}; res_c = s1_val_q[0]; end
      OP_ZERO: begin res = '0; res_c = 1'b0; end
      default: ;
    endcase

    s2_valid_d = s2_load || (s2_valid_q && !out_ready);
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    s2_tag_d   = s2_tag_q;
    if (s2_load) begin
      s2_data_d  = res;
      s2_carry_d = res_c;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_PASS;
      s1_amt_q   <= '0;
      s1_val_q   <= '0;
      s1_cin_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_amt_q   <= s1_amt_d;
      s1_val_q   <= s1_val_d;
      s1_cin_q   <= s1_cin_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign shifted_data = s2_data_q;
  assign carry_out    = s2_carry_q;
  assign out_tag      = s2_tag_q;

endmodule

// File: tb/tb_arm_shift_pipe.sv
module tb_arm_shift_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode, shift_type;
  logic [4:0]  shamt_imm;
  logic [7:0]  rs_amt, imm8;
  logic [31:0] rm_data, shifted_data;
  logic [3:0]  rot4, in_tag, out_tag;
  logic [23:0] branch_offset;
  logic        carry_in, carry_out;

  arm_shift_pipe #(.DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .shift_type(shift_type), .shamt_imm(shamt_imm), .rs_amt(rs_amt),
    .rm_data(rm_data), .imm8(imm8), .rot4(rot4), .branch_offset(branch_offset),
    .carry_in(carry_in), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .shifted_data(shifted_data), .carry_out(carry_out), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, n_acc = 0;
  bit last_acc;
  bit use_exp = 1'b0;
  logic [31:0] exp_d;
  logic        exp_c;
  logic [3:0]  tag_ctr = 4'd0;
  logic [31:0] q_d[$];
  logic        q_c[$];
  logic [3:0]  q_t[$];
  int          q_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: operand-2 rules written directly as arithmetic on 32-bit values.
  function automatic logic [32:0] model(input logic [1:0] md, input logic [1:0] st,
      input logic [4:0] sa, input logic [7:0] rs, input logic [31:0] rm,
      input logic [7:0] i8, input logic [3:0] r4, input logic [23:0] off, input logic ci);
    logic [31:0] r;
    logic c;
    int n;
    logic signed [63:0] sx;
    sx = {{32{rm[31]}}, rm};
    r = rm;
    c = ci;
    case (md)
      2'd0: begin
        n = int'(sa);
        case (st)
          2'd0: if (n != 0) begin r = rm << n; c = rm[32-n]; end
          2'd1: begin if (n == 0) n = 32; r = (n == 32) ? 32'd0 : rm >> n; c = rm[n-1]; end
          2'd2: begin if (n == 0) n = 32; sx = sx >>> n; r = sx[31:0]; c = rm[n-1]; end
          default: if (n == 0) begin r = {ci, rm[31:1]}; c = rm[0]; end
                   else begin r = rotr(rm, n); c = r[31]; end
        endcase
      end
      2'd1: begin
        n = int'(rs);
        if (n != 0) begin
          case (st)
            2'd0: if (n < 32) begin r = rm << n; c = rm[32-n]; end
                  else if (n == 32) begin r = 0; c = rm[0]; end
                  else begin r = 0; c = 0; end
            2'd1: if (n < 32) begin r = rm >> n; c = rm[n-1]; end
                  else if (n == 32) begin r = 0; c = rm[31]; end
                  else begin r = 0; c = 0; end
            2'd2: if (n < 32) begin sx = sx >>> n; r = sx[31:0]; c = rm[n-1]; end
                  else begin r = {32{rm[31]}}; c = rm[31]; end
            default: begin r = rotr(rm, n % 32); c = r[31]; end
          endcase
        end
      end
      2'd2: begin
        n = (2 * int'(r4)) % 32;
        r = rotr({24'd0, i8}, n);
        c = (r4 == 4'd0) ? ci : r[31];
      end
      default: begin r = {{6{off[23]}}, off, 2'b00}; c = ci; end
    endcase
    return {c, r};
  endfunction

  // One clock: check outputs against the scoreboard at the falling edge,
  // record accept/emit that happen on the following rising edge.
  task automatic step();
    logic [32:0] m;
    bit exp_ov;
    @(negedge clk);
    exp_ov = 1'b0;
    if (q_d.size() > 0) exp_ov = (cyc - q_cyc[0]) >= 2;
    chk("in_ready", 64'(in_ready), 64'(!(q_d.size() == 2 && !out_ready)));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (out_valid) begin
      if (q_d.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        chk("data", 64'(shifted_data), 64'(q_d[0]));
        chk("carry", 64'(carry_out), 64'(q_c[0]));
        chk("tag", 64'(out_tag), 64'(q_t[0]));
        if (out_ready) begin
          void'(q_d.pop_front()); void'(q_c.pop_front());
          void'(q_t.pop_front()); void'(q_cyc.pop_front());
        end
      end
    end
    last_acc = 1'b0;
    if (in_valid && in_ready) begin
      m = use_exp ? {exp_c, exp_d}
                  : model(mode, shift_type, shamt_imm, rs_amt, rm_data, imm8, rot4, branch_offset, carry_in);
      q_d.push_back(m[31:0]); q_c.push_back(m[32]); q_t.push_back(in_tag); q_cyc.push_back(cyc);
      last_acc = 1'b1;
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_op();
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) break;
    end
    chk("accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic next_tag();
    tag_ctr = tag_ctr + 4'd1;
    in_tag = tag_ctr;
  endtask

  task automatic dir(input logic [1:0] md, input logic [1:0] st, input logic [4:0] sa,
      input logic [7:0] rs, input logic [31:0] rm, input logic [7:0] i8, input logic [3:0] r4,
      input logic [23:0] off, input logic ci, input logic [31:0] ed, input logic ec);
    mode = md; shift_type = st; shamt_imm = sa; rs_amt = rs; rm_data = rm;
    imm8 = i8; rot4 = r4; branch_offset = off; carry_in = ci;
    exp_d = ed; exp_c = ec; use_exp = 1'b1;
    next_tag();
    send_op();
    use_exp = 1'b0;
  endtask

  task automatic rand_fields();
    mode = 2'($urandom_range(0, 3));
    shift_type = 2'($urandom_range(0, 3));
    shamt_imm = 5'($urandom);
    case ($urandom_range(0, 5))
      0: rs_amt = 8'd0;
      1: rs_amt = 8'd32;
      2: rs_amt = 8'($urandom_range(1, 31));
      3: rs_amt = 8'($urandom_range(33, 255));
      4: rs_amt = 8'($urandom);
      default: rs_amt = {3'($urandom), 5'd0};
    endcase
    rm_data = $urandom;
    imm8 = 8'($urandom);
    rot4 = 4'($urandom);
    branch_offset = 24'($urandom);
    carry_in = 1'($urandom);
    next_tag();
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
    chk("drained", 64'(q_d.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 0; shift_type = 0; shamt_imm = 0; rs_amt = 0; rm_data = 0;
    imm8 = 0; rot4 = 0; branch_offset = 0; carry_in = 0; in_tag = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(shifted_data), 64'd0);
    chk("rst_carry", 64'(carry_out), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();

    // mode, type, shamt, rs, rm, imm8, rot4, offset, cin, expected data, expected C
    dir(2'd0, 2'd0, 5'd4, 8'd0,   32'h8000000F, 8'd0,   4'd0, 24'd0,      1'b0, 32'h000000F0, 1'b0);
    dir(2'd0, 2'd1, 5'd0, 8'd0,   32'h80000001, 8'd0,   4'd0, 24'd0,      1'b0, 32'h00000000, 1'b1);
    dir(2'd1, 2'd3, 5'd0, 8'h24,  32'h12345678, 8'd0,   4'd0, 24'd0,      1'b0, 32'h81234567, 1'b1);
    dir(2'd1, 2'd2, 5'd0, 8'hFF,  32'h80000000, 8'd0,   4'd0, 24'd0,      1'b0, 32'hFFFFFFFF, 1'b1);
    dir(2'd1, 2'd0, 5'd0, 8'd32,  32'h00000001, 8'd0,   4'd0, 24'd0,      1'b0, 32'h00000000, 1'b1);
    dir(2'd2, 2'd0, 5'd0, 8'd0,   32'h0,        8'hFF,  4'd4, 24'd0,      1'b0, 32'hFF000000, 1'b1);
    dir(2'd2, 2'd0, 5'd0, 8'd0,   32'h0,        8'hFF,  4'd0, 24'd0,      1'b1, 32'h000000FF, 1'b1);
    dir(2'd0, 2'd3, 5'd0, 8'd0,   32'h00000003, 8'd0,   4'd0, 24'd0,      1'b1, 32'h80000001, 1'b1);
    dir(2'd3, 2'd1, 5'd0, 8'd0,   32'hDEADBEEF, 8'd0,   4'd0, 24'hFFFFFE, 1'b0, 32'hFFFFFFF8, 1'b0);
    dir(2'd3, 2'd2, 5'd0, 8'd0,   32'hDEADBEEF, 8'd0,   4'd0, 24'h000003, 1'b1, 32'h0000000C, 1'b1);
    dir(2'd1, 2'd1, 5'd0, 8'd33,  32'hFFFFFFFF, 8'd0,   4'd0, 24'd0,      1'b1, 32'h00000000, 1'b0);
    dir(2'd1, 2'd3, 5'd0, 8'd64,  32'h80000001, 8'd0,   4'd0, 24'd0,      1'b0, 32'h80000001, 1'b1);
    dir(2'd1, 2'd2, 5'd0, 8'd0,   32'h80000000, 8'd0,   4'd0, 24'd0,      1'b1, 32'h80000000, 1'b1);
    drain(4);

    // back-pressure: two accepted, then intake stalls while outputs hold
    out_ready = 1'b0;
    rand_fields(); send_op();
    rand_fields(); send_op();
    rand_fields();
    in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("bp_stall", 64'(last_acc), 64'd0);
    end
    out_ready = 1'b1;
    send_op();
    repeat (3) begin rand_fields(); send_op(); end
    drain(5);

    // reset with both stages full discards everything
    out_ready = 1'b0;
    rand_fields(); send_op();
    rand_fields(); send_op();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q_d.delete(); q_c.delete(); q_t.delete(); q_cyc.delete();
    chk("rst_full_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full_in_ready", 64'(in_ready), 64'd1);
    chk("rst_full_data", 64'(shifted_data), 64'd0);
    drain(4);

    // random traffic with random stalls
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || last_acc) rand_fields();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
